// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths and forwarding-source encoding.
package rv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Ordered from oldest (register file) to youngest (EX) producer.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand against the EX/MEM/WB producers and the RF read data.
// The youngest matching producer wins. If that producer's result is not ready yet,
// the hazard output is raised.
module operand_bypass
    import rv_pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic              use_op,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_ok,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_ok,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [XLEN-1:0]   rf_data,
    output logic [XLEN-1:0]   value,
    output logic              hazard,
    output fwd_src_e          src
);

    logic live;

    // Operands that are unused, or that name x0, never match a producer.
    // They always read as zero.
    assign live = use_op && (rs != '0);

    // Priority select, youngest producer first.
    always_comb begin
        src    = FWD_RF;
        value  = rf_data;
        hazard = 1'b0;
        if (!live) begin
            value = '0;
        end else if (ex_wr && (ex_rd == rs)) begin
            src    = FWD_EX;
            value  = ex_data;
            hazard = !ex_ok;
        end else if (mem_wr && (mem_rd == rs)) begin
            src    = FWD_MEM;
            value  = mem_data;
            hazard = !mem_ok;
        end else if (wb_en && (wb_rd == rs)) begin
            src    = FWD_WB;
            value  = wb_data;
        end
    end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch. It drives the RF read ports and bypasses EX/MEM/WB
// results. It stalls on unresolved RAW hazards and holds the ID/EX pipeline register
// behind a valid/ready handshake.
module id_operand_fetch
    import rv_pipe_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr,
    input  logic              in_load,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_ok,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_ok,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr,
    output logic              out_load,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [XLEN-1:0] op1_val;
    logic [XLEN-1:0] op2_val;
    logic            byp1_hazard;
    logic            byp2_hazard;
    fwd_src_e        src1;
    fwd_src_e        src2;
    logic            hazard1;
    logic            hazard2;
    logic            accept;
    logic            stall;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    operand_bypass u_byp1 (
        .rs       (in_rs1),
        .use_op   (in_use1),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd),
        .ex_ok    (ex_ok),
        .ex_data  (ex_data),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_ok   (mem_ok),
        .mem_data (mem_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_data  (rf_rd1),
        .value    (op1_val),
        .hazard   (byp1_hazard),
        .src      (src1)
    );

    operand_bypass u_byp2 (
        .rs       (in_rs2),
        .use_op   (in_use2),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd),
        .ex_ok    (ex_ok),
        .ex_data  (ex_data),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_ok   (mem_ok),
        .mem_data (mem_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_data  (rf_rd2),
        .value    (op2_val),
        .hazard   (byp2_hazard),
        .src      (src2)
    );

    // Only an in-flight EX or MEM producer can be pending. RF and WB data are always final.
    assign hazard1 = byp1_hazard && ((src1 == FWD_EX) || (src1 == FWD_MEM));
    assign hazard2 = byp2_hazard && ((src2 == FWD_EX) || (src2 == FWD_MEM));

    assign in_ready = !flush && !hazard1 && !hazard2 && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready && !flush;

    // ID/EX register: reset, then flush, then accept, then drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            out_load  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_op1   <= op1_val;
            out_op2   <= op2_val;
            out_rd    <= in_rd;
            out_wr    <= in_wr;
            out_load  <= in_load;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where a presented instruction could not issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: a vector table for the bypass/hazard cases
// plus hand sequences for back-pressure, flush and reset.
module tb_id_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use1, in_use2, in_wr, in_load;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_wr, ex_ok, mem_wr, mem_ok, wb_en;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_wr, out_load;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    id_operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
        .in_rd(in_rd), .in_wr(in_wr), .in_load(in_load),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_ok(ex_ok), .ex_data(ex_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ok(mem_ok), .mem_data(mem_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_wr(out_wr), .out_load(out_load),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        vld;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [31:0] rf1, rf2;
        logic        exw;
        logic [4:0]  exrd;
        logic        exok;
        logic [31:0] exd;
        logic        mw;
        logic [4:0]  mrd;
        logic        mok;
        logic [31:0] md;
        logic        wbe;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] op1, op2;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t dflt();
        vec_t v;
        v.vld = 1'b1; v.rs1 = '0; v.rs2 = '0; v.u1 = 1'b0; v.u2 = 1'b0;
        v.rf1 = '0; v.rf2 = '0;
        v.exw = 1'b0; v.exrd = '0; v.exok = 1'b1; v.exd = '0;
        v.mw = 1'b0; v.mrd = '0; v.mok = 1'b1; v.md = '0;
        v.wbe = 1'b0; v.wrd = '0; v.wd = '0;
        v.rdy = 1'b1; v.op1 = '0; v.op2 = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        in_valid = v.vld; in_pc = 32'h100 + 32'(idx * 4);
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_use1 = v.u1; in_use2 = v.u2;
        in_rd = 5'(idx); in_wr = 1'b1; in_load = idx[0];
        rf_rd1 = v.rf1; rf_rd2 = v.rf2;
        ex_wr = v.exw; ex_rd = v.exrd; ex_ok = v.exok; ex_data = v.exd;
        mem_wr = v.mw; mem_rd = v.mrd; mem_ok = v.mok; mem_data = v.md;
        wb_en = v.wbe; wb_rd = v.wrd; wb_data = v.wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rf_only(input logic [4:0] rs1, input logic [31:0] rf1, input logic [31:0] pc);
        vec_t v;
        v = dflt();
        v.rs1 = rs1; v.u1 = 1'b1; v.rf1 = rf1;
        apply(v, 0);
        in_pc = pc;
    endtask

    initial begin
        vec_t v;

        // Table: out_ready=1 throughout, so each accepted instruction appears after one edge.
        v = dflt(); v.rs1 = 5; v.u1 = 1; v.rf1 = 32'h99; v.exw = 1; v.exrd = 5; v.exd = 32'h11;
        v.op1 = 32'h11; vt[0] = v;
        v = dflt(); v.rs2 = 3; v.u2 = 1; v.rf2 = 32'h77;
        v.exw = 1; v.exrd = 3; v.exd = 32'hA; v.mw = 1; v.mrd = 3; v.md = 32'hB;
        v.wbe = 1; v.wrd = 3; v.wd = 32'hC; v.op2 = 32'hA; vt[1] = v;
        v.exw = 0; v.op2 = 32'hB; vt[2] = v;
        v.mw = 0; v.op2 = 32'hC; vt[3] = v;
        v = dflt(); v.rs1 = 0; v.u1 = 1; v.rf1 = 32'h5555;
        v.exw = 1; v.exrd = 0; v.exok = 0; v.exd = 32'hFFFF; v.mw = 1; v.mrd = 0; v.mok = 0; v.md = 32'hFFFF;
        v.wbe = 1; v.wrd = 0; v.wd = 32'hFFFF; v.op1 = 0; vt[4] = v;
        v = dflt(); v.rs1 = 4; v.u1 = 1; v.rf1 = 32'h44; v.rs2 = 6; v.u2 = 1; v.rf2 = 32'h66;
        v.op1 = 32'h44; v.op2 = 32'h66; vt[5] = v;
        v = dflt(); v.rs1 = 5; v.u1 = 0; v.rf1 = 32'h99; v.exw = 1; v.exrd = 5; v.exok = 0; v.exd = 32'h11;
        v.op1 = 0; vt[6] = v;
        v = dflt(); v.rs1 = 7; v.u1 = 1; v.rf1 = 32'h1; v.exw = 1; v.exrd = 7; v.exok = 0; v.rdy = 0; vt[7] = v;
        v = dflt(); v.rs1 = 7; v.u1 = 1; v.rf1 = 32'h1; v.mw = 1; v.mrd = 7; v.md = 32'h1234;
        v.op1 = 32'h1234; vt[8] = v;
        v = dflt(); v.rs2 = 9; v.u2 = 1; v.mw = 1; v.mrd = 9; v.mok = 0; v.md = 32'h9; v.rdy = 0; vt[9] = v;
        v = dflt(); v.rs2 = 9; v.u2 = 1; v.exw = 1; v.exrd = 9; v.exd = 32'hE9;
        v.mw = 1; v.mrd = 9; v.mok = 0; v.md = 32'h9; v.op2 = 32'hE9; vt[10] = v;
        v = dflt(); v.rs1 = 8; v.u1 = 1; v.rf1 = 32'h80; v.wbe = 1; v.wrd = 8; v.wd = 32'hB8;
        v.rs2 = 8; v.u2 = 1; v.rf2 = 32'h80; v.op1 = 32'hB8; v.op2 = 32'hB8; vt[11] = v;
        v = dflt(); v.vld = 0; v.rs1 = 2; v.u1 = 1; v.rf1 = 32'h22; vt[12] = v;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        apply(dflt(), 0);
        in_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_out_op1", out_op1, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        step();

        for (int i = 0; i < NV; i++) begin
            apply(vt[i], i);
            #3;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_raddr1", i), 32'(rf_raddr1), 32'(vt[i].rs1));
            if (vt[i].vld && !vt[i].rdy) exp_stall++;
            step();
            chk($sformatf("v%0d_stall_cnt", i), stall_cnt, 32'(exp_stall));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].vld && vt[i].rdy));
            if (vt[i].vld && vt[i].rdy) begin
                chk($sformatf("v%0d_out_op1", i), out_op1, vt[i].op1);
                chk($sformatf("v%0d_out_op2", i), out_op2, vt[i].op2);
                chk($sformatf("v%0d_out_pc", i), out_pc, 32'h100 + 32'(i * 4));
                chk($sformatf("v%0d_out_rd", i), 32'(out_rd), 32'(i));
                chk($sformatf("v%0d_out_load", i), 32'(out_load), 32'(i % 2));
            end
        end

        // Back-pressure: first instruction lands, EX then refuses it for three cycles.
        out_ready = 1'b0;
        set_rf_only(5'd10, 32'h55, 32'h200);
        step();
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_op1", out_op1, 32'h55);
        set_rf_only(5'd11, 32'h66, 32'h204);
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("bp_c%0d_in_ready", c), 32'(in_ready), 32'd0);
            exp_stall++;
            step();
            chk($sformatf("bp_c%0d_op1_held", c), out_op1, 32'h55);
            chk($sformatf("bp_c%0d_pc_held", c), out_pc, 32'h200);
            chk($sformatf("bp_c%0d_valid", c), 32'(out_valid), 32'd1);
        end
        chk("bp_stall_cnt", stall_cnt, 32'(exp_stall));
        out_ready = 1'b1;
        #3;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_next_op1", out_op1, 32'h66);
        chk("bp_next_pc", out_pc, 32'h204);
        chk("bp_next_valid", 32'(out_valid), 32'd1);

        // Flush while out_valid=1 and a load-use hazard is present.
        out_ready = 1'b0;
        set_rf_only(5'd12, 32'h0, 32'h208);
        ex_wr = 1'b1; ex_rd = 5'd12; ex_ok = 1'b0;
        flush = 1'b1;
        #3;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_stall_cnt", stall_cnt, 32'(exp_stall));

        // Reset in the middle of a stall drops the pending instruction.
        out_ready = 1'b1;
        step();
        exp_stall++;
        chk("rst_pre_stall_cnt", stall_cnt, 32'(exp_stall));
        ex_ok = 1'b1;
        ex_rd = 5'd0;
        step();
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        ex_rd = 5'd12; ex_ok = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
        chk("rst_mid_out_pc", out_pc, 32'd0);
        chk("rst_mid_out_op1", out_op1, 32'd0);
        chk("rst_mid_out_rd", 32'(out_rd), 32'd0);
        chk("rst_mid_out_wr", 32'(out_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
